mem_bus_arbiter: RTL and testbench

- Two-master round-robin arbiter for the native PicoRV32-style memory bus (valid/ready/addr/wdata/wstrb/rdata).
- Shares one slave memory/peripheral port between two requesters, e.g. CPU core and a DMA engine or second core.
- Registers the granted request toward the slave and returns one ready pulse to the owning master.
- A watchdog terminates transactions the slave never acknowledges.

---
 rtl/mem_bus_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for a PicoRV32-style native memory bus.
// One registered slave request at a time, one ready pulse back to the owner, and a watchdog for unanswered requests.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES != 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES != 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [1:0]        grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              s_valid_q, s_valid_d;
    logic              s_instr_q, s_instr_d;
    logic [31:0]       s_addr_q, s_addr_d;
    logic [31:0]       s_wdata_q, s_wdata_d;
    logic [3:0]        s_wstrb_q, s_wstrb_d;
    logic              m0_ready_q, m0_ready_d;
    logic              m1_ready_q, m1_ready_d;
    logic [31:0]       m0_rdata_q, m0_rdata_d;
    logic [31:0]       m1_rdata_q, m1_rdata_d;
    logic              timeout_err_q, timeout_err_d;
    logic              pick_m0, pick_m1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            grant_q       <= '0;
            cnt_q         <= '0;
            s_valid_q     <= 1'b0;
            s_instr_q     <= 1'b0;
            s_addr_q      <= '0;
            s_wdata_q     <= '0;
            s_wstrb_q     <= '0;
            m0_ready_q    <= 1'b0;
            m1_ready_q    <= 1'b0;
            m0_rdata_q    <= '0;
            m1_rdata_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            cnt_q         <= cnt_d;
            s_valid_q     <= s_valid_d;
            s_instr_q     <= s_instr_d;
            s_addr_q      <= s_addr_d;
            s_wdata_q     <= s_wdata_d;
            s_wstrb_q     <= s_wstrb_d;
            m0_ready_q    <= m0_ready_d;
            m1_ready_q    <= m1_ready_d;
            m0_rdata_q    <= m0_rdata_d;
            m1_rdata_q    <= m1_rdata_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // On a tie the master that was not served last wins.
    assign pick_m0 = m0_valid && (!m1_valid || last_grant_q);
    assign pick_m1 = m1_valid && !pick_m0;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        cnt_d         = cnt_q;
        s_valid_d     = s_valid_q;
        s_instr_d     = s_instr_q;
        s_addr_d      = s_addr_q;
        s_wdata_d     = s_wdata_q;
        s_wstrb_d     = s_wstrb_q;
        m0_ready_d    = 1'b0;
        m1_ready_d    = 1'b0;
        m0_rdata_d    = m0_rdata_q;
        m1_rdata_d    = m1_rdata_q;
        timeout_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_m0 || pick_m1) begin
                    s_instr_d    = pick_m1 ? m1_instr : m0_instr;
                    s_addr_d     = pick_m1 ? m1_addr  : m0_addr;
                    s_wdata_d    = pick_m1 ? m1_wdata : m0_wdata;
                    s_wstrb_d    = pick_m1 ? m1_wstrb : m0_wstrb;
                    s_valid_d    = 1'b1;
                    grant_d      = {pick_m1, pick_m0};
                    last_grant_d = pick_m1;
                    cnt_d        = '0;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A slave acknowledge on the watchdog's last cycle still counts as a normal completion.
                if (s_ready) begin
                    if (grant_q[1]) begin
                        m1_rdata_d = s_rdata;
                        m1_ready_d = 1'b1;
                    end else begin
                        m0_rdata_d = s_rdata;
                        m0_ready_d = 1'b1;
                    end
                    s_valid_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                    if (grant_q[1]) begin
                        m1_rdata_d = ERR_RDATA;
                        m1_ready_d = 1'b1;
                    end else begin
                        m0_rdata_d = ERR_RDATA;
                        m0_ready_d = 1'b1;
                    end
                    timeout_err_d = 1'b1;
                    s_valid_d     = 1'b0;
                    state_d       = ST_RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign s_valid     = s_valid_q;
    assign s_instr     = s_instr_q;
    assign s_addr      = s_addr_q;
    assign s_wdata     = s_wdata_q;
    assign s_wstrb     = s_wstrb_q;
    assign grant       = grant_q;
    assign m0_ready    = m0_ready_q;
    assign m1_ready    = m1_ready_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios then random traffic, every cycle compared
// against a transaction-level model of the arbiter's ownership rules.
module tb_mem_bus_arbiter;

    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_valid = 0, m1_valid = 0, m0_instr = 0, m1_instr = 0;
    logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
    logic [3:0]  m0_wstrb = 0, m1_wstrb = 0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_instr;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready = 0;
    logic [31:0] s_rdata = 0;
    logic [1:0]  grant;
    logic        timeout_err;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Model: who owns the slave (waiting for it), who is being answered, and what was latched.
    int          own_wait = -1;
    int          own_resp = -1;
    bit          resp_by_watchdog;
    int          waited;
    int          served_last = 1;
    logic [31:0] exp_rdata [2];
    logic        req_instr;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;

    int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
    int ready_seen [2];
    int tout_seen;

    task automatic model_reset();
        own_wait = -1;
        own_resp = -1;
        resp_by_watchdog = 0;
        waited = 0;
        served_last = 1;
        exp_rdata[0] = 0;
        exp_rdata[1] = 0;
    endtask

    task automatic model_edge();
        int w;
        if (own_resp >= 0) begin
            own_resp = -1;
            resp_by_watchdog = 0;
        end else if (own_wait >= 0) begin
            if (s_ready) begin
                exp_rdata[own_wait] = s_rdata;
                own_resp = own_wait;
                own_wait = -1;
            end else if (waited == TO - 1) begin
                exp_rdata[own_wait] = ERR;
                own_resp = own_wait;
                own_wait = -1;
                resp_by_watchdog = 1;
            end else begin
                waited++;
            end
        end else if (m0_valid || m1_valid) begin
            if (m0_valid && m1_valid) w = 1 - served_last;
            else w = m1_valid ? 1 : 0;
            req_instr = w ? m1_instr : m0_instr;
            req_addr  = w ? m1_addr  : m0_addr;
            req_wdata = w ? m1_wdata : m0_wdata;
            req_wstrb = w ? m1_wstrb : m0_wstrb;
            own_wait = w;
            served_last = w;
            waited = 0;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int owner;
        owner = (own_wait >= 0) ? own_wait : own_resp;
        check_output("s_valid", 32'(s_valid), 32'(own_wait >= 0));
        check_output("grant", 32'(grant), (owner < 0) ? 32'd0 : 32'(1 << owner));
        check_output("m0_ready", 32'(m0_ready), 32'(own_resp == 0));
        check_output("m1_ready", 32'(m1_ready), 32'(own_resp == 1));
        check_output("timeout_err", 32'(timeout_err), 32'(own_resp >= 0 && resp_by_watchdog));
        check_output("m0_rdata", m0_rdata, exp_rdata[0]);
        check_output("m1_rdata", m1_rdata, exp_rdata[1]);
        if (own_wait >= 0) begin
            check_output("s_instr", 32'(s_instr), 32'(req_instr));
            check_output("s_addr", s_addr, req_addr);
            check_output("s_wdata", s_wdata, req_wdata);
            check_output("s_wstrb", 32'(s_wstrb), 32'(req_wstrb));
        end
        if (m0_ready === 1'b1) ready_seen[0]++;
        if (m1_ready === 1'b1) ready_seen[1]++;
        if (timeout_err === 1'b1) tout_seen++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic apply_stimulus(input int idx, input logic v, input logic ins,
                                  input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        if (idx == 0) begin
            m0_valid = v; m0_instr = ins; m0_addr = a; m0_wdata = d; m0_wstrb = st;
        end else begin
            m1_valid = v; m1_instr = ins; m1_addr = a; m1_wdata = d; m1_wstrb = st;
        end
    endtask

    task automatic drain();
        m0_valid = 0;
        m1_valid = 0;
        s_ready = 1;
        repeat (4) tick();
    endtask

    initial begin
        int stall;

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        resetn = 1;

        // Single read from m0 with an always-ready slave
        ready_seen[0] = 0; ready_seen[1] = 0;
        s_ready = 1;
        s_rdata = 32'h1234_5678;
        apply_stimulus(0, 1, 0, 32'h0000_0010, 0, 4'b0000);
        tick();
        check_output("single_s_addr", s_addr, 32'h10);
        m0_valid = 0;
        repeat (3) tick();
        check_output("single_m0_ready_cnt", 32'(ready_seen[0]), 32'd1);
        check_output("single_m1_ready_cnt", 32'(ready_seen[1]), 32'd0);

        // Both masters valid continuously: strict alternation
        drain();
        ready_seen[0] = 0; ready_seen[1] = 0;
        apply_stimulus(0, 1, 0, 32'h100, 0, 4'b0000);
        apply_stimulus(1, 1, 1, 32'h200, 0, 4'b0000);
        for (int i = 0; i < 12; i++) begin
            s_rdata = 32'hA000_0000 + i;
            tick();
        end
        check_output("alt_m0_ready_cnt", 32'(ready_seen[0]), 32'd2);
        check_output("alt_m1_ready_cnt", 32'(ready_seen[1]), 32'd2);

        // m1 write held while the slave stalls
        drain();
        s_ready = 0;
        apply_stimulus(1, 1, 0, 32'h1000_0000, 32'h41, 4'b0001);
        tick();
        m1_valid = 0;
        repeat (3) tick();
        check_output("wr_s_wstrb", 32'(s_wstrb), 32'h1);
        s_ready = 1;
        repeat (3) tick();

        // Watchdog termination, then a normal transaction
        drain();
        tout_seen = 0;
        s_ready = 0;
        apply_stimulus(0, 1, 0, 32'h2000, 0, 4'b0000);
        tick();
        m0_valid = 0;
        repeat (11) tick();
        check_output("wd_tout_cnt", 32'(tout_seen), 32'd1);
        check_output("wd_m0_rdata", m0_rdata, ERR);
        s_ready = 1;
        s_rdata = 32'h5555_AAAA;
        apply_stimulus(1, 1, 0, 32'h3000, 0, 4'b0000);
        tick();
        m1_valid = 0;
        repeat (3) tick();

        // Slow slave, m1 arrives during m0's BUSY
        drain();
        s_ready = 0;
        s_rdata = 32'hCAFE_0001;
        apply_stimulus(0, 1, 0, 32'h4000, 0, 4'b0000);
        tick();
        m0_valid = 0;
        tick();
        apply_stimulus(1, 1, 1, 32'h5000, 32'h77, 4'b1111);
        repeat (3) tick();
        s_ready = 1;
        tick();
        s_ready = 0;
        repeat (3) tick();
        m1_valid = 0;
        s_rdata = 32'hCAFE_0002;
        s_ready = 1;
        repeat (3) tick();

        // Random traffic with stall bursts to reach the watchdog
        drain();
        stall = 0;
        for (int i = 0; i < 400; i++) begin
            if (i % 20 == 0) stall = ($urandom_range(0, 3) == 0) ? 1 : 0;
            apply_stimulus(0, ($urandom_range(0, 9) < 6), 1'($urandom), $urandom, $urandom, 4'($urandom));
            apply_stimulus(1, ($urandom_range(0, 9) < 6), 1'($urandom), $urandom, $urandom, 4'($urandom));
            s_ready = stall ? 1'b0 : 1'($urandom);
            s_rdata = $urandom;
            tick();
        end

        // Asynchronous reset during BUSY, then the first tie goes to m0
        drain();
        s_ready = 0;
        apply_stimulus(0, 1, 0, 32'h6000, 0, 4'b0000);
        tick();
        m0_valid = 0;
        tick();
        #2;
        resetn = 0;
        #1;
        model_reset();
        check_output("rst_s_valid", 32'(s_valid), 32'd0);
        check_output("rst_grant", 32'(grant), 32'd0);
        check_output("rst_m0_ready", 32'(m0_ready), 32'd0);
        @(negedge clk);
        resetn = 1;
        s_ready = 1;
        apply_stimulus(0, 1, 0, 32'h7000, 0, 4'b0000);
        apply_stimulus(1, 1, 0, 32'h8000, 0, 4'b0000);
        tick();
        check_output("rst_tie_grant", 32'(grant), 32'd1);
        m0_valid = 0;
        m1_valid = 0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
